// File: rtl/track_pkg.sv
// rtl/track_pkg.sv - shared types and constants for the tracking overlay path
// Lock states, overlay select codes, overlay colours and default frame geometry.
// The measurement stage uses the same frame geometry.
package track_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    COAST  = 2'd2
  } lock_state_t;

  typedef enum logic [1:0] {
    OVL_NONE  = 2'd0,
    OVL_BOX   = 2'd1,
    OVL_COAST = 2'd2
  } ovl_sel_t;

  // Overlay colours as {R,G,B} channel masks. Each set channel is driven to full
  // scale, so the colours follow any COLOR_WIDTH.
  localparam logic [2:0] BOX_COLOR   = 3'b100;  // full red
  localparam logic [2:0] COAST_COLOR = 3'b110;  // full yellow

endpackage

// File: rtl/track_pixel_counter.sv
// rtl/track_pixel_counter.sv - x/y raster counter for a pixel stream
// Ports: clk, areset (async, active high), pixel_valid, sof -> x, y.
// x/y give the coordinate of the current valid pixel. An sof pixel is (0,0).
// x wraps at H_ACTIVE-1 and y saturates at V_ACTIVE. Both hold while pixel_valid is low.
module track_pixel_counter #(
  parameter int INPUT_WIDTH = 11,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   pixel_valid,
  input  logic                   sof,
  output logic [INPUT_WIDTH-1:0] x,
  output logic [INPUT_WIDTH-1:0] y
);

  logic [INPUT_WIDTH-1:0] x_q;
  logic [INPUT_WIDTH-1:0] y_q;
  logic                   restart;

  // The registers hold the coordinate of the next pixel. An sof restarts the count in the same cycle.
  assign restart = pixel_valid & sof;
  assign x       = restart ? '0 : x_q;
  assign y       = restart ? '0 : y_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pixel_valid) begin
      if (x == INPUT_WIDTH'(H_ACTIVE - 1)) begin
        x_q <= '0;
        y_q <= (y == INPUT_WIDTH'(V_ACTIVE)) ? y : y + 1'b1;
      end else begin
        x_q <= x + 1'b1;
        y_q <= y;
      end
    end
  end

endmodule

// File: rtl/track_overlay.sv
// rtl/track_overlay.sv - draws a tracking box and centre marker on an RGB stream
// Ports: clk, areset (async, active high); pixel_in/pixel_valid_in/sof_in stream in;
// x_position/y_position/valid_position centroid in; pixel_out/pixel_valid_out/sof_out
// stream out (2-cycle latency); lock is high while LOCKED or COAST.
module track_overlay
  import track_pkg::*;
#(
  parameter int INPUT_WIDTH = 11,
  parameter int COLOR_WIDTH = 10,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int BOX_HALF    = 16,
  parameter int MISS_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic [3*COLOR_WIDTH-1:0] pixel_in,
  input  logic                     pixel_valid_in,
  input  logic                     sof_in,
  input  logic [26:0]              x_position,
  input  logic [26:0]              y_position,
  input  logic                     valid_position,
  output logic [3*COLOR_WIDTH-1:0] pixel_out,
  output logic                     pixel_valid_out,
  output logic                     sof_out,
  output logic                     lock
);

  localparam int DW = INPUT_WIDTH + 1;
  localparam logic [3*COLOR_WIDTH-1:0] BOX_RGB = {{COLOR_WIDTH{BOX_COLOR[2]}},
      {COLOR_WIDTH{BOX_COLOR[1]}}, {COLOR_WIDTH{BOX_COLOR[0]}}};
  localparam logic [3*COLOR_WIDTH-1:0] COAST_RGB = {{COLOR_WIDTH{COAST_COLOR[2]}},
      {COLOR_WIDTH{COAST_COLOR[1]}}, {COLOR_WIDTH{COAST_COLOR[0]}}};

  logic [INPUT_WIDTH-1:0] px, py;
  logic [INPUT_WIDTH-1:0] pend_x, pend_y, cx, cy, cx_use, cy_use, x_clamp, y_clamp;
  logic                   pend_flag, commit;
  logic [3:0]             miss_cnt, miss_nxt;
  lock_state_t            state, state_nxt;
  logic [DW-1:0]          dx, dy, adx, ady;
  logic                   box_hit, centre_hit;
  ovl_sel_t               sel, s1_sel;
  logic [3*COLOR_WIDTH-1:0] s1_pixel;
  logic                   s1_valid, s1_sof;

  track_pixel_counter #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE)
  ) u_counter (
    .clk        (clk),
    .areset     (areset),
    .pixel_valid(pixel_valid_in),
    .sof        (sof_in),
    .x          (px),
    .y          (py)
  );

  assign commit  = pixel_valid_in & sof_in;
  assign x_clamp = (x_position > 27'(H_ACTIVE - 1)) ? INPUT_WIDTH'(H_ACTIVE - 1)
                                                    : x_position[INPUT_WIDTH-1:0];
  assign y_clamp = (y_position > 27'(V_ACTIVE - 1)) ? INPUT_WIDTH'(V_ACTIVE - 1)
                                                    : y_position[INPUT_WIDTH-1:0];

  // Frame commit. The sof pixel is drawn with the centre and state it commits.
  always_comb begin
    cx_use    = cx;
    cy_use    = cy;
    miss_nxt  = miss_cnt;
    state_nxt = state;
    if (commit) begin
      if (pend_flag) begin
        cx_use    = pend_x;
        cy_use    = pend_y;
        miss_nxt  = '0;
        state_nxt = LOCKED;
      end else begin
        if (miss_cnt != 4'(MISS_LIMIT)) miss_nxt = miss_cnt + 4'd1;
        unique case (state)
          LOCKED:  state_nxt = COAST;
          COAST:   if (miss_nxt == 4'(MISS_LIMIT)) state_nxt = SEARCH;
          default: state_nxt = SEARCH;
        endcase
      end
    end
  end

  // Zero-extended subtraction yields a signed difference. Off-screen box parts
  // never match an on-screen coordinate, so clipping needs no extra logic.
  always_comb begin
    dx         = {1'b0, px} - {1'b0, cx_use};
    dy         = {1'b0, py} - {1'b0, cy_use};
    adx        = dx[DW-1] ? (~dx + 1'b1) : dx;
    ady        = dy[DW-1] ? (~dy + 1'b1) : dy;
    box_hit    = ((adx == DW'(BOX_HALF)) && (ady <= DW'(BOX_HALF))) ||
                 ((ady == DW'(BOX_HALF)) && (adx <= DW'(BOX_HALF)));
    centre_hit = (adx == '0) && (ady == '0);
  end

  always_comb begin
    sel = OVL_NONE;
    if (pixel_valid_in && (py < INPUT_WIDTH'(V_ACTIVE))) begin
      if ((state_nxt == LOCKED) && (box_hit || centre_hit)) sel = OVL_BOX;
      else if ((state_nxt == COAST) && box_hit)             sel = OVL_COAST;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state           <= SEARCH;
      cx              <= '0;
      cy              <= '0;
      pend_x          <= '0;
      pend_y          <= '0;
      pend_flag       <= 1'b0;
      miss_cnt        <= 4'(MISS_LIMIT);
      lock            <= 1'b0;
      s1_valid        <= 1'b0;
      s1_sof          <= 1'b0;
      s1_pixel        <= '0;
      s1_sel          <= OVL_NONE;
      pixel_valid_out <= 1'b0;
      sof_out         <= 1'b0;
      pixel_out       <= '0;
    end else begin
      // Stage 1: pixel, compare result and frame commit.
      s1_valid <= pixel_valid_in;
      s1_sof   <= commit;
      s1_pixel <= pixel_valid_in ? pixel_in : '0;
      s1_sel   <= sel;
      if (commit) begin
        cx       <= cx_use;
        cy       <= cy_use;
        miss_cnt <= miss_nxt;
        state    <= state_nxt;
        lock     <= (state_nxt != SEARCH);
      end
      // A capture that coincides with sof is kept for the following frame.
      if (valid_position) begin
        pend_x    <= x_clamp;
        pend_y    <= y_clamp;
        pend_flag <= 1'b1;
      end else if (commit) begin
        pend_flag <= 1'b0;
      end
      // Stage 2: colour mux.
      pixel_valid_out <= s1_valid;
      sof_out         <= s1_sof;
      unique case (s1_sel)
        OVL_BOX:   pixel_out <= BOX_RGB;
        OVL_COAST: pixel_out <= COAST_RGB;
        default:   pixel_out <= s1_pixel;
      endcase
    end
  end

endmodule

// File: tb/tb_track_overlay.sv
// tb/tb_track_overlay.sv - self-checking bench for track_overlay
module tb_track_overlay;

  localparam int MISS_LIMIT = 4;
  localparam logic [29:0] RED = 30'h3FF00000;
  localparam logic [29:0] YEL = 30'h3FFFFC00;
  localparam int NP = 32;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [29:0] pixel_in = '0;
  logic        pixel_valid_in = 1'b0;
  logic        sof_in = 1'b0;
  logic [26:0] x_position = '0;
  logic [26:0] y_position = '0;
  logic        valid_position = 1'b0;
  logic [29:0] pixel_out;
  logic        pixel_valid_out;
  logic        sof_out;
  logic        lock;

  int n_tests = 0;
  int n_fail = 0;
  int hits = 0;
  int frame_id = 0;
  logic [31:0] seed = 32'h1234_5678;

  track_overlay dut (
    .clk            (clk),
    .areset         (areset),
    .pixel_in       (pixel_in),
    .pixel_valid_in (pixel_valid_in),
    .sof_in         (sof_in),
    .x_position     (x_position),
    .y_position     (y_position),
    .valid_position (valid_position),
    .pixel_out      (pixel_out),
    .pixel_valid_out(pixel_valid_out),
    .sof_out        (sof_out),
    .lock           (lock)
  );

  always #5 clk = ~clk;

  // Hand-computed probe points: frame, x, y, kind (0 pass-through, 1 red, 2 yellow).
  int pr_f [NP] = '{2,2,2,2,2,2,2,2, 3,3,3,3,3,3, 4,4,4,4,4,4, 5, 6,6,6,6, 7, 8, 9, 10,10, 11,11};
  int pr_x [NP] = '{304,336,303,337,304,320,320,321, 5,0,21,22,629,0, 639,623,623,622,0,15,
                    320, 320,304,320,304, 320, 320, 320, 50,100, 100,50};
  int pr_y [NP] = '{0,0,0,0,10,16,15,16, 3,19,10,10,5,10, 4,4,0,4,4,4,
                    0, 0,0,16,16, 0, 0, 0, 2,3, 3,2};
  int pr_k [NP] = '{1,1,0,0,1,1,0,0, 1,1,1,0,0,0, 1,1,1,0,0,0, 1, 2,2,0,2, 2, 2, 0, 1,0, 1,0};

  typedef struct packed {
    logic        valid;
    logic        sof;
    logic [29:0] pin;
    logic [29:0] pix;
    int          x;
    int          y;
    int          f;
  } exp_t;

  exp_t d1, exp_now, nx;
  int   mx, my, mcx, mcy, pnx, pny, miss, mst;
  bit   pflag, m_lock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // What the frame should look like at (x,y) given the committed centre and lock state.
  function automatic logic [29:0] expect_pix(input int x, input int y, input logic [29:0] pin,
                                             input int st, input int cx, input int cy);
    int ax, ay;
    bit box, ctr;
    ax  = iabs(x - cx);
    ay  = iabs(y - cy);
    box = (ax == 16 && ay <= 16) || (ay == 16 && ax <= 16);
    ctr = (ax == 0 && ay == 0);
    if (y >= 480) return pin;
    if (st == 1 && (box || ctr)) return RED;
    if (st == 2 && box) return YEL;
    return pin;
  endfunction

  // Reference model: frame-level bookkeeping plus a 2-deep output delay.
  always @(posedge clk) begin
    if (areset) begin
      mst = 0; mcx = 0; mcy = 0; pflag = 0; miss = MISS_LIMIT;
      mx = 0; my = 0; m_lock = 0; d1 = '0; exp_now = '0;
    end else begin
      exp_now = d1;
      nx = '0;
      if (pixel_valid_in) begin
        if (sof_in) begin
          mx = 0; my = 0;
          if (pflag) begin
            mcx = pnx; mcy = pny; pflag = 0; miss = 0; mst = 1;
          end else begin
            miss = (miss < MISS_LIMIT) ? miss + 1 : MISS_LIMIT;
            if (mst == 1) mst = 2;
            else if (mst == 2 && miss == MISS_LIMIT) mst = 0;
          end
          m_lock = (mst != 0);
        end
        nx.valid = 1'b1;
        nx.sof   = sof_in;
        nx.pin   = pixel_in;
        nx.pix   = expect_pix(mx, my, pixel_in, mst, mcx, mcy);
        nx.x     = mx;
        nx.y     = my;
        nx.f     = frame_id;
        mx++;
        if (mx == 640) begin
          mx = 0;
          if (my < 480) my++;
        end
      end
      if (valid_position) begin
        pnx = (x_position > 27'd639) ? 639 : int'(x_position);
        pny = (y_position > 27'd479) ? 479 : int'(y_position);
        pflag = 1;
      end
      d1 = nx;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (areset) begin
      chk("reset_outputs", 64'({pixel_out, pixel_valid_out, sof_out, lock}), 64'(0));
    end else begin
      chk("pixel_valid_out", 64'(pixel_valid_out), 64'(exp_now.valid));
      chk("sof_out", 64'(sof_out), 64'(exp_now.sof));
      chk("lock", 64'(lock), 64'(m_lock));
      chk("pixel_out", 64'(pixel_out), 64'(exp_now.pix));
      if (exp_now.valid) begin
        for (int j = 0; j < NP; j++) begin
          if (pr_f[j] == exp_now.f && pr_x[j] == exp_now.x && pr_y[j] == exp_now.y) begin
            hits++;
            chk($sformatf("probe f%0d (%0d,%0d)", pr_f[j], pr_x[j], pr_y[j]), 64'(pixel_out),
                64'((pr_k[j] == 1) ? RED : (pr_k[j] == 2) ? YEL : exp_now.pin));
          end
        end
      end
    end
  end

  task automatic drive(input bit v, input bit s, input bit p, input int xp, input int yp);
    pixel_valid_in = v;
    sof_in         = s;
    valid_position = p;
    x_position     = 27'(xp);
    y_position     = 27'(yp);
    seed           = seed * 32'd1664525 + 32'd1013904223;
    pixel_in       = v ? seed[31:2] : 30'h0;
    @(posedge clk);
    #2;
  endtask

  // One frame of `lines` lines, with occasional idle cycles. The position pulse
  // lands on pixel pulse_at, or on the sof pixel itself when co is set.
  task automatic run_frame(input int lines, input int pulse_at, input int pxp, input int pyp,
                           input bit co, input int cxp, input int cyp);
    frame_id++;
    for (int i = 0; i < lines * 640; i++) begin
      if (i % 53 == 26) drive(0, 0, 0, 0, 0);
      if (i == 0 && co) drive(1, 1, 1, cxp, cyp);
      else drive(1, i == 0, i == pulse_at, pxp, pyp);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    areset = 1'b0;
    run_frame(2, 100, 320, 16, 0, 0, 0);
    chk("lock_no_position", 64'(lock), 64'(0));
    run_frame(17, 100, 5, 3, 0, 0, 0);
    chk("lock_after_update", 64'(lock), 64'(1));
    run_frame(20, 100, 2000, 4, 0, 0, 0);
    run_frame(5, 100, 320, 16, 0, 0, 0);
    run_frame(1, -1, 0, 0, 0, 0, 0);
    run_frame(17, -1, 0, 0, 0, 0, 0);
    chk("lock_coast1", 64'(lock), 64'(1));
    run_frame(1, -1, 0, 0, 0, 0, 0);
    run_frame(1, -1, 0, 0, 0, 0, 0);
    chk("lock_coast3", 64'(lock), 64'(1));
    run_frame(1, 10, 50, 2, 0, 0, 0);
    chk("lock_lost", 64'(lock), 64'(0));
    run_frame(4, -1, 0, 0, 1, 100, 3);
    chk("lock_coincident", 64'(lock), 64'(1));
    run_frame(4, -1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) drive(1, 0, 0, 0, 0);
    areset = 1'b1;
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
    areset = 1'b0;
    for (int i = 0; i < 640; i++) drive(1, 0, 0, 0, 0);
    chk("lock_after_reset", 64'(lock), 64'(0));
    run_frame(1, -1, 0, 0, 0, 0, 0);
    chk("lock_search_after_reset", 64'(lock), 64'(0));
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
    chk("probe_hits", 64'(hits), 64'(NP));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
